// File: rtl/pipelined_cla_if.sv
// ---------------------------------------------------------------------------
// pipelined_cla_if
// Streaming bus for the pipelined carry-lookahead adder/subtractor.
//
// Upstream (operand) side:
//   in_valid  : operand beat valid
//   in_ready  : adder can accept a beat this cycle
//   a, b      : operands (width bits)
//   cin       : carry-in
//   sub       : 0 = a + b + cin, 1 = a - b - cin
// Downstream (result) side:
//   out_valid : result valid
//   out_ready : consumer accepts the result this cycle
//   s         : sum / difference (width bits)
//   cout      : carry out of the MSB (in subtract mode 1 = no borrow)
//   ovf       : two's-complement signed overflow
//
// modport slave  : the adder's view
// modport master : the view of whatever drives operands and takes results
// ---------------------------------------------------------------------------
interface pipelined_cla_if #(
  parameter int width = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] a;
  logic [width-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla.sv
// ---------------------------------------------------------------------------
// pipelined_cla
// Parametrised pipelined carry-lookahead adder/subtractor with a valid/ready
// stream on both sides. The width-bit add is cut into `stages` slices; stage
// k adds slice k with block-bit lookahead groups and hands its carry to
// stage k+1 through a register. One beat per cycle when nothing stalls,
// latency = `stages` register stages (the last one is the output register).
//
// Parameters:
//   width  : operand / sum width
//   block  : lookahead group size in bits
//   stages : pipeline depth; width/stages must be a whole number of groups
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, empties the pipeline
//   bus   : pipelined_cla_if.slave (operands in, result out, handshakes)
// ---------------------------------------------------------------------------
module pipelined_cla #(
  parameter int width  = 32,
  parameter int block  = 4,
  parameter int stages = 4
) (
  input  logic           clk,
  input  logic           reset,
  pipelined_cla_if.slave bus
);

  localparam int SW = width / stages;  // slice width added per stage
  localparam int NG = SW / block;      // lookahead groups per slice

  if ((width % stages) != 0 || (SW % block) != 0) begin : g_param_check
    $error("pipelined_cla: width must split into stages slices of whole block-bit groups");
  end

  for (genvar gi = 0; gi < stages; gi++) begin : g_stage
    // Operand bits still to be added when the beat reaches this stage
    // (this stage's slice plus everything above it).
    localparam int REM = width - gi * SW;

    logic [REM-1:0]        a_cur;
    logic [REM-1:0]        b_cur;
    logic                  c_cur;
    logic                  up_valid;
    logic                  down_ready;
    logic                  stage_ready;
    logic                  load;
    logic                  vld_q;
    logic                  c_q;
    logic [SW-1:0]         g_bits;
    logic [SW-1:0]         p_bits;
    logic [SW-1:0]         carry_int;
    logic [SW-1:0]         sum_slice;
    logic                  c_slice_out;
    logic                  grp_c;
    logic                  grp_g;
    logic                  grp_p;
    logic [(gi+1)*SW-1:0]  s_d;
    logic [(gi+1)*SW-1:0]  s_q;

    // ---- beat source: bus for stage 0, previous stage register otherwise
    if (gi == 0) begin : g_src
      // Subtraction is a + ~b + 1; folding sub into cin lets cin=1 mean
      // "minus one more" in subtract mode.
      assign a_cur    = bus.a;
      assign b_cur    = bus.b ^ {width{bus.sub}};
      assign c_cur    = bus.cin ^ bus.sub;
      assign up_valid = bus.in_valid;
      assign s_d      = sum_slice;
    end else begin : g_src
      assign a_cur    = g_stage[gi-1].g_fwd.a_q;
      assign b_cur    = g_stage[gi-1].g_fwd.b_q;
      assign c_cur    = g_stage[gi-1].c_q;
      assign up_valid = g_stage[gi-1].vld_q;
      assign s_d      = {sum_slice, g_stage[gi-1].s_q};
    end

    // ---- ready comes from the next stage, or the consumer for the last one
    if (gi == stages - 1) begin : g_dn
      assign down_ready = bus.out_ready;
    end else begin : g_dn
      assign down_ready = g_stage[gi+1].stage_ready;
    end

    // A stage may take a new beat if it is empty or its beat leaves now;
    // this is what lets bubbles collapse behind a stalled output.
    assign stage_ready = ~vld_q | down_ready;
    assign load        = up_valid & stage_ready;

    // ---- slice adder: per-bit g/p, then lookahead inside each group.
    // carry_int[i] is the carry into bit i; within a group it is the
    // prefix generate/propagate from the group base applied to the group
    // carry-in, so no bit waits on a ripple through its neighbours.
    always_comb begin
      g_bits    = a_cur[SW-1:0] & b_cur[SW-1:0];
      p_bits    = a_cur[SW-1:0] ^ b_cur[SW-1:0];
      carry_int = '0;
      grp_c     = c_cur;
      grp_g     = 1'b0;
      grp_p     = 1'b1;
      for (int gr = 0; gr < NG; gr++) begin
        grp_g = 1'b0;
        grp_p = 1'b1;
        for (int j = 0; j < block; j++) begin
          carry_int[gr*block+j] = grp_g | (grp_p & grp_c);
          grp_g = g_bits[gr*block+j] | (p_bits[gr*block+j] & grp_g);
          grp_p = grp_p & p_bits[gr*block+j];
        end
        grp_c = grp_g | (grp_p & grp_c);
      end
      c_slice_out = grp_c;
      sum_slice   = p_bits ^ carry_int;
    end

    // ---- stage valid: set on load, cleared when handed off without refill
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q <= 1'b0;
      end else begin
        vld_q <= load | (vld_q & ~down_ready);
      end
    end

    // ---- completed sum slices and the carry into the next slice.
    // Registers only move on load, so a stalled output holds its value.
    always_ff @(posedge clk) begin
      if (reset) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (load) begin
        s_q <= s_d;
        c_q <= c_slice_out;
      end
    end

    if (gi < stages - 1) begin : g_fwd
      // Upper operand slices travel with the beat until their stage.
      logic [REM-SW-1:0] a_q;
      logic [REM-SW-1:0] b_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load) begin
          a_q <= a_cur[REM-1:SW];
          b_q <= b_cur[REM-1:SW];
        end
      end
    end else begin : g_last
      // Carry into the MSB; XOR with the carry out gives signed overflow.
      logic c_msb_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          c_msb_q <= 1'b0;
        end else if (load) begin
          c_msb_q <= carry_int[SW-1];
        end
      end
    end
  end

  assign bus.in_ready  = g_stage[0].stage_ready;
  assign bus.out_valid = g_stage[stages-1].vld_q;
  assign bus.s         = g_stage[stages-1].s_q;
  assign bus.cout      = g_stage[stages-1].c_q;
  assign bus.ovf       = g_stage[stages-1].g_last.c_msb_q ^ g_stage[stages-1].c_q;

endmodule
